// File: rtl/cash_ctrl_pkg.sv
// Shared types and helpers for the cash data cell slot manager.
package cash_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_DELETE
`ifdef CASH_FLUSH_EN
    , ST_FLUSH
`endif
  } state_t;

  typedef enum logic {
    GNT_INS = 1'b0,
    GNT_DEL = 1'b1
  } gnt_t;

  // Slot index width; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/cash_cell_manager_if.sv
// Insert/delete request bundle between the hashtable logic and the slot manager.
interface cash_cell_manager_if
  import cash_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_SIZE   = 128
);
  localparam int unsigned IDX_W = idx_width(MEM_SIZE);

  logic                  ins_valid;
  logic                  ins_ready;
  logic [DATA_WIDTH-1:0] ins_data;
  logic                  ins_done;
  logic [IDX_W-1:0]      ins_idx;
  logic                  del_valid;
  logic                  del_ready;
  logic [IDX_W-1:0]      del_idx;
  logic                  del_done;
  logic                  del_err;

  modport master (
    output ins_valid, ins_data, del_valid, del_idx,
    input  ins_ready, ins_done, ins_idx, del_ready, del_done, del_err
  );

  modport slave (
    input  ins_valid, ins_data, del_valid, del_idx,
    output ins_ready, ins_done, ins_idx, del_ready, del_done, del_err
  );
endinterface

// File: rtl/cash_free_finder.sv
// Lowest-numbered free slot over the valid bitmap (combinational).
module cash_free_finder
  import cash_ctrl_pkg::*;
#(
  parameter  int unsigned MEM_SIZE = 128,
  localparam int unsigned IDX_W    = idx_width(MEM_SIZE)
) (
  input  logic [MEM_SIZE-1:0] valid,
  output logic [IDX_W-1:0]    free_idx,
  output logic                any_free
);
  always_comb begin
    free_idx = '0;
    any_free = 1'b0;
    for (int i = int'(MEM_SIZE) - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        free_idx = IDX_W'(i);
        any_free = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cash_cell_manager.sv
// Slot allocator / strobe driver for the cash data cell array.
// Optional flush of all valid slots when CASH_FLUSH_EN is defined.
module cash_cell_manager
  import cash_ctrl_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned MEM_SIZE   = 128,
  localparam int unsigned IDX_W      = idx_width(MEM_SIZE),
  localparam int unsigned CNT_W      = $clog2(MEM_SIZE + 1)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  cash_cell_manager_if.slave                   bus,
  input  logic                                 rd_en,
  input  logic [IDX_W-1:0]                     rd_idx,
  output logic [DATA_WIDTH-1:0]                rd_data,
  output logic                                 rd_hit,
  output logic [DATA_WIDTH-1:0]                cell_data,
  output logic                                 cell_cs,
  output logic [MEM_SIZE-1:0]                  cell_we,
  output logic [MEM_SIZE-1:0]                  cell_del,
  input  logic [MEM_SIZE-1:0][DATA_WIDTH-1:0]  cell_q,
`ifdef CASH_FLUSH_EN
  input  logic                                 flush,
  output logic                                 flush_done,
`endif
  output logic                                 full,
  output logic                                 empty,
  output logic [CNT_W-1:0]                     count
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_SIZE);

  state_t                state, state_nx;
  gnt_t                  last_gnt;
  logic                  gnt_ins, gnt_del, ins_req, del_req;
  logic [MEM_SIZE-1:0]   valid, valid_nx;
  logic [CNT_W-1:0]      count_nx;
  logic [IDX_W-1:0]      free_idx;
  logic                  any_free;
  logic                  ins_ready_nx, del_ready_nx, ins_done_nx, del_done_nx, del_err_nx;
  logic [IDX_W-1:0]      ins_idx_nx;
  logic                  cell_cs_nx;
  logic [MEM_SIZE-1:0]   cell_we_nx, cell_del_nx;
  logic [DATA_WIDTH-1:0] cell_data_nx;
`ifdef CASH_FLUSH_EN
  logic                  gnt_flush;
`endif

  cash_free_finder #(.MEM_SIZE(MEM_SIZE)) u_free_finder (
    .valid    (valid),
    .free_idx (free_idx),
    .any_free (any_free)
  );

  assign ins_req = bus.ins_valid && bus.ins_ready && any_free;
  assign del_req = bus.del_valid && bus.del_ready;

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Arbitration: flush first, then alternate insert/delete on contention.
  always_comb begin
    state_nx = state;
    gnt_ins  = 1'b0;
    gnt_del  = 1'b0;
`ifdef CASH_FLUSH_EN
    gnt_flush = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
`ifdef CASH_FLUSH_EN
        if (flush) gnt_flush = 1'b1;
        else
`endif
        if (ins_req && del_req) begin
          if (last_gnt == GNT_INS) gnt_del = 1'b1;
          else                     gnt_ins = 1'b1;
        end else begin
          gnt_ins = ins_req;
          gnt_del = del_req;
        end
        if (gnt_ins)      state_nx = ST_WRITE;
        else if (gnt_del) state_nx = ST_DELETE;
`ifdef CASH_FLUSH_EN
        if (gnt_flush)    state_nx = ST_FLUSH;
`endif
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Bitmap/count update for the finishing op, and next values of the strobes.
  always_comb begin
    valid_nx     = valid;
    count_nx     = count;
    cell_cs_nx   = 1'b0;
    cell_we_nx   = '0;
    cell_del_nx  = '0;
    cell_data_nx = '0;
    ins_done_nx  = 1'b0;
    ins_idx_nx   = bus.ins_idx;
    del_done_nx  = 1'b0;
    del_err_nx   = 1'b0;
    case (state)
      ST_WRITE: begin
        valid_nx = valid | cell_we;
        if (count != CNT_MAX) count_nx = count + CNT_W'(1);
      end
      ST_DELETE: begin
        valid_nx = valid & ~cell_del;
        if (bus.del_done && count != '0) count_nx = count - CNT_W'(1);
      end
`ifdef CASH_FLUSH_EN
      ST_FLUSH: begin
        valid_nx = '0;
        count_nx = '0;
      end
`endif
      default: ;
    endcase
    if (gnt_ins) begin
      cell_cs_nx           = 1'b1;
      cell_we_nx[free_idx] = 1'b1;
      cell_data_nx         = bus.ins_data;
      ins_done_nx          = 1'b1;
      ins_idx_nx           = free_idx;
    end
    if (gnt_del) begin
      if (valid[bus.del_idx]) begin
        cell_cs_nx               = 1'b1;
        cell_del_nx[bus.del_idx] = 1'b1;
        del_done_nx              = 1'b1;
      end else begin
        del_err_nx = 1'b1;
      end
    end
`ifdef CASH_FLUSH_EN
    if (gnt_flush) begin
      cell_cs_nx  = |valid;
      cell_del_nx = valid;
    end
`endif
    ins_ready_nx = (state_nx == ST_IDLE) && (count_nx != CNT_MAX);
    del_ready_nx = (state_nx == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid         <= '0;
      count         <= '0;
      full          <= 1'b0;
      empty         <= 1'b1;
      last_gnt      <= GNT_INS;
      bus.ins_ready <= 1'b1;
      bus.del_ready <= 1'b1;
      bus.ins_done  <= 1'b0;
      bus.ins_idx   <= '0;
      bus.del_done  <= 1'b0;
      bus.del_err   <= 1'b0;
      cell_cs       <= 1'b0;
      cell_we       <= '0;
      cell_del      <= '0;
      cell_data     <= '0;
`ifdef CASH_FLUSH_EN
      flush_done    <= 1'b0;
`endif
    end else begin
      valid         <= valid_nx;
      count         <= count_nx;
      full          <= (count_nx == CNT_MAX);
      empty         <= (count_nx == '0);
      if (gnt_ins)      last_gnt <= GNT_INS;
      else if (gnt_del) last_gnt <= GNT_DEL;
      bus.ins_ready <= ins_ready_nx;
      bus.del_ready <= del_ready_nx;
      bus.ins_done  <= ins_done_nx;
      bus.ins_idx   <= ins_idx_nx;
      bus.del_done  <= del_done_nx;
      bus.del_err   <= del_err_nx;
      cell_cs       <= cell_cs_nx;
      cell_we       <= cell_we_nx;
      cell_del      <= cell_del_nx;
      cell_data     <= cell_data_nx;
`ifdef CASH_FLUSH_EN
      flush_done    <= gnt_flush;
`endif
    end
  end

  // Indexed read port, independent of the FSM; holds when rd_en is low.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data <= '0;
      rd_hit  <= 1'b0;
    end else if (rd_en) begin
      rd_data <= cell_q[rd_idx];
      rd_hit  <= valid[rd_idx];
    end
  end
endmodule

// File: tb/tb_cash_cell_manager.sv
// Bench for cash_cell_manager: slot-level model plus directed sequences (flush part under CASH_FLUSH_EN).
module tb_cash_cell_manager;
  localparam int unsigned N  = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 3;
  localparam int unsigned CW = 4;

  logic clk = 1'b0;
  logic reset;
  logic rd_en;
  logic [IW-1:0] rd_idx;
  logic [DW-1:0] rd_data, cell_data;
  logic rd_hit, cell_cs, full, empty;
  logic [N-1:0] cell_we, cell_del;
  logic [N-1:0][DW-1:0] mem = '0;
  logic [CW-1:0] count;
`ifdef CASH_FLUSH_EN
  logic flush, flush_done;
`endif

  int tests = 0;
  int fails = 0;

  cash_cell_manager_if #(.DATA_WIDTH(DW), .MEM_SIZE(N)) bus ();

  cash_cell_manager #(.DATA_WIDTH(DW), .MEM_SIZE(N)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd_data), .rd_hit(rd_hit),
    .cell_data(cell_data), .cell_cs(cell_cs), .cell_we(cell_we), .cell_del(cell_del),
    .cell_q(mem),
`ifdef CASH_FLUSH_EN
    .flush(flush), .flush_done(flush_done),
`endif
    .full(full), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  // Cell array stand-in: written on the strobe edge.
  always @(posedge clk) begin
    for (int i = 0; i < int'(N); i++)
      if (cell_cs && cell_we[i]) mem[i] <= cell_data;
  end

  task automatic cmp(input string nm, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  // Model: set of occupied slots and which op (if any) is on the array this cycle.
  bit started = 1'b0;
  logic [N-1:0] m_valid;
  bit prefer_del;
  int m_pend;
  logic e_ins_ready, e_del_ready, e_ins_done, e_del_done, e_del_err, e_cs, e_rd_hit, e_flush_done;
  logic [IW-1:0] e_ins_idx;
  logic [N-1:0] e_we, e_del;
  logic [DW-1:0] e_data, e_rd_data;
  int e_count;

  always @(posedge clk) begin
    bit idle, gi, gd, gf, wi, wd;
    int slot;
    started = 1'b1;
    if (!reset) begin
      m_valid = '0; prefer_del = 1'b1; m_pend = 0;
      e_ins_ready = 1'b1; e_del_ready = 1'b1;
      e_ins_done = 1'b0; e_del_done = 1'b0; e_del_err = 1'b0; e_flush_done = 1'b0;
      e_cs = 1'b0; e_we = '0; e_del = '0; e_data = '0; e_ins_idx = '0;
      e_rd_data = '0; e_rd_hit = 1'b0; e_count = 0;
    end else begin
      if (rd_en) begin
        e_rd_data = mem[rd_idx];
        e_rd_hit  = m_valid[rd_idx];
      end
      if (e_ins_done)   m_valid[e_ins_idx] = 1'b1;
      if (e_del_done)   m_valid[m_pend] = 1'b0;
      if (e_flush_done) m_valid = '0;
      idle = e_del_ready;
      gi = 1'b0; gd = 1'b0; gf = 1'b0;
`ifdef CASH_FLUSH_EN
      if (idle) gf = flush;
`endif
      if (idle && !gf) begin
        wi = bus.ins_valid && e_ins_ready;
        wd = bus.del_valid;
        if (wi && wd) begin gd = prefer_del; gi = !prefer_del; end
        else begin gi = wi; gd = wd; end
      end
      e_ins_done = 1'b0; e_del_done = 1'b0; e_del_err = 1'b0; e_flush_done = 1'b0;
      e_cs = 1'b0; e_we = '0; e_del = '0; e_data = '0;
      if (gi) begin
        slot = 0;
        for (int i = int'(N) - 1; i >= 0; i--) if (!m_valid[i]) slot = i;
        e_ins_done = 1'b1; e_ins_idx = IW'(slot); e_cs = 1'b1; e_we[slot] = 1'b1;
        e_data = bus.ins_data; prefer_del = 1'b1;
      end
      if (gd) begin
        prefer_del = 1'b0; m_pend = int'(bus.del_idx);
        if (m_valid[m_pend]) begin e_del_done = 1'b1; e_cs = 1'b1; e_del[m_pend] = 1'b1; end
        else e_del_err = 1'b1;
      end
      if (gf) begin
        e_flush_done = 1'b1; e_del = m_valid; e_cs = (m_valid != '0);
      end
      e_count     = $countones(m_valid);
      e_del_ready = !(gi || gd || gf);
      e_ins_ready = e_del_ready && (e_count != int'(N));
    end
  end

  always @(negedge clk) begin
    if (started) begin
      cmp("ins_ready", 64'(bus.ins_ready), 64'(e_ins_ready));
      cmp("del_ready", 64'(bus.del_ready), 64'(e_del_ready));
      cmp("ins_done",  64'(bus.ins_done),  64'(e_ins_done));
      if (e_ins_done) cmp("ins_idx", 64'(bus.ins_idx), 64'(e_ins_idx));
      cmp("del_done",  64'(bus.del_done),  64'(e_del_done));
      cmp("del_err",   64'(bus.del_err),   64'(e_del_err));
      cmp("cell_cs",   64'(cell_cs),       64'(e_cs));
      cmp("cell_we",   64'(cell_we),       64'(e_we));
      cmp("cell_del",  64'(cell_del),      64'(e_del));
      if (e_we != '0) cmp("cell_data", 64'(cell_data), 64'(e_data));
      cmp("rd_data",   64'(rd_data),       64'(e_rd_data));
      cmp("rd_hit",    64'(rd_hit),        64'(e_rd_hit));
      cmp("count",     64'(count),         64'(e_count));
      cmp("full",      64'(full),          64'(e_count == int'(N)));
      cmp("empty",     64'(empty),         64'(e_count == 0));
`ifdef CASH_FLUSH_EN
      cmp("flush_done", 64'(flush_done),   64'(e_flush_done));
`endif
    end
  end

  // Returns at the negedge of the WRITE cycle.
  task automatic do_ins(input logic [DW-1:0] d);
    int n = 0;
    @(negedge clk);
    bus.ins_valid = 1'b1; bus.ins_data = d;
    while (!bus.ins_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.ins_valid = 1'b0;
    cmp("ins_accept_wait", 64'(n < 50), 64'd1);
  endtask

  // Returns at the negedge of the DELETE cycle.
  task automatic do_del(input logic [IW-1:0] idx);
    int n = 0;
    @(negedge clk);
    bus.del_valid = 1'b1; bus.del_idx = idx;
    while (!bus.del_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.del_valid = 1'b0;
    cmp("del_accept_wait", 64'(n < 50), 64'd1);
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
  endtask

  initial begin
    int n, g;
    logic [3:0] seq;
    bus.ins_valid = 1'b0; bus.ins_data = '0; bus.del_valid = 1'b0; bus.del_idx = '0;
    rd_en = 1'b0; rd_idx = '0; reset = 1'b0;
`ifdef CASH_FLUSH_EN
    flush = 1'b0;
`endif
    repeat (3) @(negedge clk);
    cmp("rst_empty", 64'(empty), 64'd1);
    cmp("rst_ins_ready", 64'(bus.ins_ready), 64'd1);
    cmp("rst_count", 64'(count), 64'd0);
    reset = 1'b1;

    do_ins(32'hA); cmp("ins_a_idx", 64'(bus.ins_idx), 64'd0);
    do_ins(32'hB); cmp("ins_b_idx", 64'(bus.ins_idx), 64'd1);
    do_ins(32'hC); cmp("ins_c_idx", 64'(bus.ins_idx), 64'd2);
    @(negedge clk); cmp("count_3", 64'(count), 64'd3);
    rd_en = 1'b1; rd_idx = 3'd1;
    @(negedge clk); rd_en = 1'b0;
    cmp("rd1_data", 64'(rd_data), 64'hB);
    cmp("rd1_hit", 64'(rd_hit), 64'd1);

    do_del(3'd1);
    cmp("del1_done", 64'(bus.del_done), 64'd1);
    cmp("del1_strobe", 64'(cell_del), 64'h02);
    do_ins(32'hD); cmp("ins_d_idx", 64'(bus.ins_idx), 64'd1);
    rd_en = 1'b1; rd_idx = 3'd1;
    @(negedge clk);
    cmp("rdw_old_data", 64'(rd_data), 64'hB);
    cmp("rdw_hit", 64'(rd_hit), 64'd0);
    @(negedge clk); rd_en = 1'b0;
    cmp("rdw_new_data", 64'(rd_data), 64'hD);
    cmp("rdw_new_hit", 64'(rd_hit), 64'd1);
    cmp("count_3b", 64'(count), 64'd3);

    do_del(3'd5);
    cmp("del5_err", 64'(bus.del_err), 64'd1);
    cmp("del5_nostrobe", 64'(cell_del), 64'd0);
    @(negedge clk); cmp("count_3c", 64'(count), 64'd3);

    // Contention right after reset: delete first, then alternate.
    pulse_reset();
    bus.ins_valid = 1'b1; bus.ins_data = 32'h55; bus.del_valid = 1'b1; bus.del_idx = 3'd0;
    n = 0; g = 0; seq = '0;
    while (g < 4 && n < 40) begin
      @(negedge clk); n++;
      if (bus.ins_done) begin seq[3-g] = 1'b1; g++; end
      else if (bus.del_done || bus.del_err) begin seq[3-g] = 1'b0; g++; end
    end
    bus.ins_valid = 1'b0; bus.del_valid = 1'b0;
    cmp("arb_grants", 64'(g), 64'd4);
    cmp("arb_order", 64'(seq), 64'b0101);

    for (int i = 1; i < int'(N); i++) begin
      do_ins(32'h100 + 32'(i));
      cmp("fill_idx", 64'(bus.ins_idx), 64'(i));
    end
    cmp("full_in_last_write", 64'(full), 64'd0);
    @(negedge clk);
    cmp("full_set", 64'(full), 64'd1);
    cmp("full_not_ready", 64'(bus.ins_ready), 64'd0);

    bus.ins_valid = 1'b1; bus.ins_data = 32'h99;
    repeat (4) begin @(negedge clk); cmp("full_blocks", 64'(bus.ins_done), 64'd0); end
    bus.del_valid = 1'b1; bus.del_idx = 3'd3;
    n = 0;
    while (!bus.del_done && n < 20) begin @(negedge clk); n++; end
    bus.del_valid = 1'b0;
    cmp("full_del_wait", 64'(n < 20), 64'd1);
    n = 0;
    while (!bus.ins_done && n < 20) begin @(negedge clk); n++; end
    bus.ins_valid = 1'b0;
    cmp("full_ins_wait", 64'(n < 20), 64'd1);
    cmp("refill_idx", 64'(bus.ins_idx), 64'd3);

`ifdef CASH_FLUSH_EN
    pulse_reset();
    do_ins(32'h1); do_ins(32'h2); do_ins(32'h3);
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    cmp("flush_done", 64'(flush_done), 64'd1);
    cmp("flush_strobe", 64'(cell_del), 64'h07);
    @(negedge clk); cmp("flush_empty", 64'(empty), 64'd1);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    cmp("flush_empty_done", 64'(flush_done), 64'd1);
    cmp("flush_empty_cs", 64'(cell_cs), 64'd0);
`endif

    // Reset during the WRITE cycle.
    pulse_reset();
    do_ins(32'h77);
    cmp("pre_rst_we", 64'(cell_we), 64'h01);
    reset = 1'b0;
    @(negedge clk);
    cmp("midrst_we", 64'(cell_we), 64'd0);
    cmp("midrst_cs", 64'(cell_cs), 64'd0);
    cmp("midrst_done", 64'(bus.ins_done), 64'd0);
    cmp("midrst_count", 64'(count), 64'd0);
    cmp("midrst_empty", 64'(empty), 64'd1);
    cmp("midrst_ready", 64'(bus.ins_ready), 64'd1);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
